// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and sequencer state type shared by ALU initiators
package alu_pkg;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_PASS1   = 2'b01;
  localparam logic [1:0] OP_PASS2   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} seq_state_e;
endpackage

// File: rtl/alu_op_sequencer_settle_counter.sv
// settle_counter: loadable down-counter with a done pulse on the last settle cycle
module settle_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign done = cnt_q == CW'(1);
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU op, waits the opcode-dependent settle time, returns o1
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DW         = 8,
  parameter int ADD_WAIT   = 3,
  parameter int PASS_WAIT  = 1,
  parameter int OPCHG_WAIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_opcode,
  input  logic [DW-1:0] req_i1,
  input  logic [DW-1:0] req_i2,
  output logic [DW-1:0] alu_i1,
  output logic [DW-1:0] alu_i2,
  output logic [1:0]    alu_opcode,
  input  logic [DW-1:0] alu_o1,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          busy
);
  localparam int MAXW = ADD_WAIT > PASS_WAIT ? ADD_WAIT : PASS_WAIT;
  localparam int CW   = $clog2(MAXW + OPCHG_WAIT + 1);
  seq_state_e    state_q, state_d;
  logic [1:0]    prev_op_q, prev_op_d, alu_op_q, alu_op_d;
  logic [DW-1:0] alu_i1_q, alu_i1_d, alu_i2_q, alu_i2_d, rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d, load, done;
  logic [CW-1:0] wait_val;
  assign wait_val = (req_opcode == OP_ADD ? CW'(ADD_WAIT) : CW'(PASS_WAIT))
                  + (req_opcode != prev_op_q ? CW'(OPCHG_WAIT) : CW'(0));
  settle_counter #(.CW(CW)) u_cnt (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(wait_val), .done(done)
  );
  always_comb begin
    state_d    = state_q;
    prev_op_d  = prev_op_q;
    alu_op_d   = alu_op_q;
    alu_i1_d   = alu_i1_q;
    alu_i2_d   = alu_i2_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    load       = 1'b0;
    if (state_q == IDLE && req_valid) begin
      if (req_opcode != OP_ILLEGAL) begin
        alu_op_d  = req_opcode;
        alu_i1_d  = req_i1;
        alu_i2_d  = req_i2;
        prev_op_d = req_opcode;
        load      = 1'b1;
        state_d   = SETTLE;
      end else begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
        state_d    = RESP;
      end
    end else if (state_q == SETTLE && done) begin
      rsp_data_d = alu_o1;
      rsp_err_d  = 1'b0;
      state_d    = RESP;
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_op_q  <= OP_ILLEGAL;
      alu_op_q   <= '0;
      alu_i1_q   <= '0;
      alu_i2_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_op_q  <= prev_op_d;
      alu_op_q   <= alu_op_d;
      alu_i1_q   <= alu_i1_d;
      alu_i2_q   <= alu_i2_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
  assign req_ready  = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign rsp_valid  = state_q == RESP;
  assign alu_i1     = alu_i1_q;
  assign alu_i2     = alu_i2_q;
  assign alu_opcode = alu_op_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed plus random ops checked against a transaction-level model
module tb_alu_op_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic [1:0] req_opcode = '0, alu_opcode;
  logic [7:0] req_i1 = '0, req_i2 = '0, alu_i1, alu_i2, alu_o1, rsp_data;
  int n_cmp = 0, n_fail = 0;
  logic [1:0] m_prev = 2'b11, m_op = 2'b00;
  logic [7:0] m_i1 = '0, m_i2 = '0;
  always #5 clk = ~clk;
  assign alu_o1 = alu_opcode == 2'b00 ? alu_i1 + alu_i2 :
                  alu_opcode == 2'b01 ? alu_i1 : alu_opcode == 2'b10 ? alu_i2 : 8'h00;
  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_i1(req_i1), .req_i2(req_i2),
    .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_opcode(alu_opcode), .alu_o1(alu_o1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_alu(input string tag);
    chk({tag, "_alu_i1"}, 32'(alu_i1), 32'(m_i1));
    chk({tag, "_alu_i2"}, 32'(alu_i2), 32'(m_i2));
    chk({tag, "_alu_op"}, 32'(alu_opcode), 32'(m_op));
  endtask
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int hold);
    int lat, exp_lat;
    logic [7:0] exp_data;
    chk("idle_ready", 32'(req_ready), 32'd1);
    exp_lat  = op == 2'b11 ? 1 : (op == 2'b00 ? 3 : 1) + (op != m_prev ? 1 : 0) + 1;
    exp_data = op == 2'b00 ? 8'(a + b) : op == 2'b01 ? a : op == 2'b10 ? b : 8'h00;
    if (op != 2'b11) begin
      m_prev = op; m_op = op; m_i1 = a; m_i2 = b;
    end
    req_valid = 1'b1; req_opcode = op; req_i1 = a; req_i2 = b;
    tick();
    req_valid = 1'b0;
    chk_alu("issue");
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_data", 32'(rsp_data), 32'(exp_data));
    chk("rsp_err", 32'(rsp_err), 32'(op == 2'b11));
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1; req_opcode = 2'($urandom); req_i1 = 8'($urandom); req_i2 = 8'($urandom);
      tick();
      req_valid = 1'b0;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'(exp_data));
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk_alu("hold");
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("drain_valid", 32'(rsp_valid), 32'd0);
    chk("drain_ready", 32'(req_ready), 32'd1);
    chk_alu("drain");
  endtask
  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk_alu("rst");
    do_op(2'b00, 8'h12, 8'h34, 0);
    do_op(2'b00, 8'h01, 8'h02, 0);
    do_op(2'b10, 8'h5C, 8'hA5, 0);
    do_op(2'b00, 8'h10, 8'h20, 0);
    do_op(2'b11, 8'hEE, 8'hDD, 0);
    do_op(2'b00, 8'h07, 8'h08, 0);
    do_op(2'b01, 8'h3C, 8'hC3, 5);
    req_valid = 1'b1; req_opcode = 2'b00; req_i1 = 8'h99; req_i2 = 8'h66;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_prev = 2'b11; m_op = 2'b00; m_i1 = '0; m_i2 = '0;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_err", 32'(rsp_err), 32'd0);
    chk_alu("midrst");
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("midrst_norsp", 32'(rsp_valid), 32'd0);
    end
    do_op(2'b01, 8'h42, 8'h24, 0);
    for (int n = 0; n < 40; n++)
      do_op(2'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
